// File: rtl/topk_pkg.sv
// Shared types and constants for the top-16 frame accumulator.
package topk_pkg;

  localparam int TOPK_N = 16;

  // Beat qualifier driven by the upstream sorter.
  typedef struct packed {
    logic valid;
    logic last;
  } ctrl_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/topk_merge_net_16.sv
// Combinational merge of a descending accumulator with a descending beat,
// producing the descending top-16 of both (elementwise max, then bitonic clean).
module topk_merge_net_16
  import topk_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic [TOPK_N-1:0][DATAWIDTH-1:0] acc,
  input  logic [TOPK_N-1:0][DATAWIDTH-1:0] x,
  output logic [TOPK_N-1:0][DATAWIDTH-1:0] merged
);

  function automatic logic [DATAWIDTH-1:0] umax(input logic [DATAWIDTH-1:0] a,
                                                input logic [DATAWIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DATAWIDTH-1:0] umin(input logic [DATAWIDTH-1:0] a,
                                                input logic [DATAWIDTH-1:0] b);
    return (a > b) ? b : a;
  endfunction

  // stg[0] is bitonic; each later stage halves the compare distance (8,4,2,1).
  logic [4:0][TOPK_N-1:0][DATAWIDTH-1:0] stg;

  always_comb begin
    stg = '0;
    for (int i = 0; i < TOPK_N; i++) begin
      stg[0][i] = umax(acc[i], x[TOPK_N-1-i]);
    end
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < TOPK_N; i++) begin
        if ((i & (8 >> s)) == 0) begin
          stg[s+1][i] = umax(stg[s][i], stg[s][i + (8 >> s)]);
        end else begin
          stg[s+1][i] = umin(stg[s][i], stg[s][i - (8 >> s)]);
        end
      end
    end
  end

  assign merged = stg[4];

endmodule

// File: rtl/topk_accum_16.sv
// Running top-16 accumulator over sorted beats, with a one-deep result register.
// Optional beat counter and frame_len_o output under `ifdef TOPK_ACCUM_CNT_EN.
module topk_accum_16
  import topk_pkg::*;
#(
  parameter int DATAWIDTH  = 8,
  parameter int DATALENGTH = 16
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  ctrl_t                           ctrl_i,
  input  logic [TOPK_N-1:0][DATAWIDTH-1:0] x_i,
  output logic [TOPK_N-1:0][DATAWIDTH-1:0] y_o,
  output logic                            y_valid_o,
  input  logic                            y_ready_i,
  output logic                            overflow_o,
`ifdef TOPK_ACCUM_CNT_EN
  output logic [15:0]                     frame_len_o,
`endif
  output out_state_e                      state_o
);

  generate
    if (DATALENGTH != TOPK_N) begin : g_bad_length
      $error("topk_accum_16 supports DATALENGTH == 16 only");
    end
  endgenerate

  // Output handshake: a result transfers on any rising edge where y_valid_o and
  // y_ready_i are both 1; while y_valid_o=1 and y_ready_i=0, y_o stays unchanged.

  logic [TOPK_N-1:0][DATAWIDTH-1:0] acc_q;
  logic [TOPK_N-1:0][DATAWIDTH-1:0] acc_in;
  logic [TOPK_N-1:0][DATAWIDTH-1:0] merged;
  logic [TOPK_N-1:0][DATAWIDTH-1:0] y_q;
  logic                             first_q;
  logic                             ovf_q;
  out_state_e                       state_q;
  out_state_e                       state_d;
  logic                             beat;
  logic                             last_beat;
  logic                             take_result;
  logic                             drop_result;

  assign beat      = ctrl_i.valid;
  assign last_beat = ctrl_i.valid & ctrl_i.last;

  // A stale accumulator is masked rather than cleared, so the last beat costs no extra cycle.
  assign acc_in = first_q ? '0 : acc_q;

  topk_merge_net_16 #(
    .DATAWIDTH(DATAWIDTH)
  ) u_merge (
    .acc   (acc_in),
    .x     (x_i),
    .merged(merged)
  );

  always_comb begin
    state_d     = state_q;
    take_result = 1'b0;
    drop_result = 1'b0;
    case (state_q)
      OUT_EMPTY: begin
        if (last_beat) begin
          take_result = 1'b1;
          state_d     = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (last_beat) begin
          if (y_ready_i) begin
            take_result = 1'b1;
          end else begin
            drop_result = 1'b1;
          end
        end else if (y_ready_i) begin
          state_d = OUT_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= OUT_EMPTY;
      acc_q   <= '0;
      first_q <= 1'b1;
      y_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (beat) begin
        acc_q   <= merged;
        first_q <= ctrl_i.last;
      end
      if (take_result) begin
        y_q <= merged;
      end
      if (drop_result) begin
        ovf_q <= 1'b1;
      end
    end
  end

`ifdef TOPK_ACCUM_CNT_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_inc;
  logic [15:0] len_q;

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      if (beat) begin
        cnt_q <= ctrl_i.last ? 16'd0 : cnt_inc;
      end
      if (take_result) begin
        len_q <= cnt_inc;
      end
    end
  end

  assign frame_len_o = len_q;
`endif

  assign y_o        = y_q;
  assign y_valid_o  = (state_q == OUT_FULL);
  assign overflow_o = ovf_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_topk_accum_16.sv
// Bench for topk_accum_16: directed scenarios plus a randomized run against a
// sort-based reference model. Frame length checks under `ifdef TOPK_ACCUM_CNT_EN.
module tb_topk_accum_16;
  import topk_pkg::*;

  localparam int W = 8;
  typedef logic [15:0][W-1:0] beat_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  ctrl_t      ctrl;
  beat_t      x;
  beat_t      y;
  logic       y_valid;
  logic       y_ready;
  logic       overflow;
  out_state_e state;
`ifdef TOPK_ACCUM_CNT_EN
  logic [15:0] frame_len;
  logic [15:0] exp_len_q[$];
`endif

  int    total = 0;
  int    bad = 0;
  beat_t exp_q[$];
  int    cur[$];
  logic  exp_ovf;

  topk_accum_16 dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .ctrl_i     (ctrl),
    .x_i        (x),
    .y_o        (y),
    .y_valid_o  (y_valid),
    .y_ready_i  (y_ready),
    .overflow_o (overflow),
`ifdef TOPK_ACCUM_CNT_EN
    .frame_len_o(frame_len),
`endif
    .state_o    (state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: the frame result is the 16 largest of all elements seen in the frame.
  function automatic beat_t top16(input int vals[$]);
    int    t[$];
    beat_t r;
    t = vals;
    t.rsort();
    for (int k = 0; k < 16; k++) r[k] = W'(t[k]);
    return r;
  endfunction

  function automatic beat_t rand_beat();
    int    t[$];
    beat_t r;
    for (int k = 0; k < 16; k++) t.push_back(int'($urandom_range(0, 255)));
    t.rsort();
    for (int k = 0; k < 16; k++) r[k] = W'(t[k]);
    return r;
  endfunction

  task automatic add_beat(input beat_t b);
    for (int k = 0; k < 16; k++) cur.push_back(int'(b[k]));
  endtask

  task automatic do_cycle(input logic v, input logic l, input beat_t b);
    ctrl.valid = v;
    ctrl.last  = l;
    x          = b;
    @(posedge clk);
    #1;
    ctrl = '0;
  endtask

  task automatic apply_reset();
    rstn    = 1'b0;
    ctrl    = '0;
    x       = '0;
    y_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    ctrl = '0;
    x    = '0;
    y_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", y_valid); end
    total++; if (y !== '0) begin bad++; $display("FAIL reset_y: got %h want 0", y); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    total++; if (state !== OUT_EMPTY) begin bad++; $display("FAIL reset_state: got %0d want EMPTY", state); end
    rstn = 1'b1;
    do_cycle(1'b0, 1'b0, '0);
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", y_valid); end
  endtask

  task automatic test_single_beat();
    beat_t b;
    apply_reset();
    for (int k = 0; k < 16; k++) b[k] = W'(15 - k);
    do_cycle(1'b1, 1'b1, b);
    total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", y_valid); end
    total++; if (y !== b) begin bad++; $display("FAIL single_y: got %h want %h", y, b); end
`ifdef TOPK_ACCUM_CNT_EN
    total++; if (frame_len !== 16'd1) begin bad++; $display("FAIL single_len: got %0d want 1", frame_len); end
`endif
    do_cycle(1'b0, 1'b0, '0);
    total++; if (y_valid !== 1'b1 || y !== b) begin bad++; $display("FAIL single_hold: got %b/%h want 1/%h", y_valid, y, b); end
    y_ready = 1'b1;
    do_cycle(1'b0, 1'b0, '0);
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL single_consume: got %b want 0", y_valid); end
  endtask

  task automatic test_two_beats();
    beat_t b1, b2, e;
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      b1[k] = W'(30 - 2 * k);
      b2[k] = W'(31 - 2 * k);
      e[k]  = W'(31 - k);
    end
    do_cycle(1'b1, 1'b0, b1);
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL two_mid_valid: got %b want 0", y_valid); end
    do_cycle(1'b1, 1'b1, b2);
    total++; if (y !== e || y_valid !== 1'b1) begin bad++; $display("FAIL two_y: got %b/%h want 1/%h", y_valid, y, e); end
`ifdef TOPK_ACCUM_CNT_EN
    total++; if (frame_len !== 16'd2) begin bad++; $display("FAIL two_len: got %0d want 2", frame_len); end
`endif
  endtask

  task automatic test_overflow();
    beat_t b1, b2, e1, sevens;
    apply_reset();
    b1 = rand_beat();
    b2 = rand_beat();
    cur.delete();
    add_beat(b1);
    add_beat(b2);
    e1 = top16(cur);
    for (int k = 0; k < 16; k++) sevens[k] = W'(7);
    do_cycle(1'b1, 1'b0, b1);
    do_cycle(1'b1, 1'b1, b2);
    total++; if (y !== e1) begin bad++; $display("FAIL ovf_first: got %h want %h", y, e1); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
    do_cycle(1'b1, 1'b1, sevens);
    total++; if (y !== e1 || y_valid !== 1'b1) begin bad++; $display("FAIL ovf_keep: got %b/%h want 1/%h", y_valid, y, e1); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
    y_ready = 1'b1;
    do_cycle(1'b0, 1'b0, '0);
    do_cycle(1'b0, 1'b0, '0);
    total++; if (overflow !== 1'b1 || y_valid !== 1'b0) begin bad++; $display("FAIL ovf_sticky: got ovf=%b valid=%b want 1/0", overflow, y_valid); end
  endtask

  task automatic test_back_to_back();
    beat_t f1, f2;
    apply_reset();
    f1 = rand_beat();
    f2 = rand_beat();
    do_cycle(1'b1, 1'b1, f1);
    y_ready = 1'b1;
    total++; if (y !== f1 || y_valid !== 1'b1) begin bad++; $display("FAIL b2b_first: got %b/%h want 1/%h", y_valid, y, f1); end
    do_cycle(1'b1, 1'b1, f2);
    total++; if (y !== f2 || y_valid !== 1'b1) begin bad++; $display("FAIL b2b_second: got %b/%h want 1/%h", y_valid, y, f2); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf: got %b want 0", overflow); end
    total++; if (state !== OUT_FULL) begin bad++; $display("FAIL b2b_state: got %0d want FULL", state); end
    do_cycle(1'b0, 1'b0, '0);
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", y_valid); end
  endtask

  task automatic test_reset_mid_frame();
    beat_t fives;
    apply_reset();
    for (int k = 0; k < 16; k++) fives[k] = W'(5);
    do_cycle(1'b1, 1'b1, rand_beat());
    do_cycle(1'b1, 1'b0, rand_beat());
    do_cycle(1'b1, 1'b0, rand_beat());
    rstn = 1'b0;
    #1;
    total++; if (y_valid !== 1'b0 || y !== '0) begin bad++; $display("FAIL async_reset: got %b/%h want 0/0", y_valid, y); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    do_cycle(1'b1, 1'b1, fives);
    total++; if (y !== fives || y_valid !== 1'b1) begin bad++; $display("FAIL midreset_y: got %b/%h want 1/%h", y_valid, y, fives); end
`ifdef TOPK_ACCUM_CNT_EN
    total++; if (frame_len !== 16'd1) begin bad++; $display("FAIL midreset_len: got %0d want 1", frame_len); end
`endif
  endtask

  task automatic test_gaps();
    beat_t b, e;
    apply_reset();
    cur.delete();
    for (int n = 0; n < 3; n++) begin
      b = rand_beat();
      add_beat(b);
      do_cycle(1'b1, (n == 2), b);
      if (n < 2) begin
        repeat ($urandom_range(1, 3)) do_cycle(1'b0, 1'b1, rand_beat());
      end
    end
    e = top16(cur);
    total++; if (y !== e || y_valid !== 1'b1) begin bad++; $display("FAIL gaps_y: got %b/%h want 1/%h", y_valid, y, e); end
`ifdef TOPK_ACCUM_CNT_EN
    total++; if (frame_len !== 16'd3) begin bad++; $display("FAIL gaps_len: got %0d want 3", frame_len); end
`endif
  endtask

  task automatic rnd_step(input logic v, input logic l, input beat_t b, input int n);
    beat_t e;
    y_ready    = 1'($urandom_range(0, 1));
    ctrl.valid = v;
    ctrl.last  = l;
    x          = b;
    if (y_valid && y_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL rnd_unexpected: got %h want no result", y);
      end else begin
        e = exp_q.pop_front();
        if (y !== e) begin bad++; $display("FAIL rnd_y: got %h want %h", y, e); end
`ifdef TOPK_ACCUM_CNT_EN
        total++;
        if (frame_len !== exp_len_q[0][15:0]) begin bad++; $display("FAIL rnd_len: got %0d want %0d", frame_len, exp_len_q[0]); end
        void'(exp_len_q.pop_front());
`endif
      end
    end
    if (v && l) begin
      if (exp_q.size() == 0) begin
        exp_q.push_back(top16(cur));
`ifdef TOPK_ACCUM_CNT_EN
        exp_len_q.push_back(16'(n));
`endif
      end else begin
        exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    ctrl = '0;
    total++; if (y_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL rnd_valid: got %b want %b", y_valid, exp_q.size() != 0); end
    total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL rnd_ovf: got %b want %b", overflow, exp_ovf); end
  endtask

  task automatic test_random();
    beat_t b;
    int    n;
    apply_reset();
    exp_q.delete();
`ifdef TOPK_ACCUM_CNT_EN
    exp_len_q.delete();
`endif
    exp_ovf = 1'b0;
    for (int f = 0; f < 150; f++) begin
      n = $urandom_range(1, 5);
      cur.delete();
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(0, 3) == 0) rnd_step(1'b0, 1'b0, rand_beat(), n);
        b = rand_beat();
        add_beat(b);
        rnd_step(1'b1, (i == n - 1), b, n);
      end
    end
    for (int i = 0; i < 20; i++) rnd_step(1'b0, 1'b0, '0, 0);
  endtask

  initial begin
    ctrl    = '0;
    x       = '0;
    y_ready = 1'b0;
    exp_ovf = 1'b0;
    test_reset();
    test_single_beat();
    test_two_beats();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    test_gaps();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
